// File: rtl/aes_link_pkg.sv
// Shared types and sizing helpers for the AES chip link engine.
package aes_link_pkg;

  typedef enum logic [1:0] {IDLE, TX_HI, TX_LO, WAIT_RX} state_t;

  localparam int TX_BYTES = 32;
  localparam int RX_BYTES = 16;
  localparam int STB      = 8;

  function automatic int calc_div(input int clk_freq, input int tx_freq);
    return clk_freq / tx_freq;
  endfunction

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/aes_link_tick.sv
// Link tick divider: counts 0..DIV-1, tick on the last count, held at 0 while clr.
module aes_link_tick
  import aes_link_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = cnt_w(DIV);

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/aes_chip_link.sv
// Link engine: streams {key,text} to the AES chip as strobed bytes, then
// collects a 16-byte result, with a tick-based timeout between result bytes.
module aes_chip_link
  import aes_link_pkg::*;
#(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int AES_TX_FREQ   = 50_000,
  parameter int TIMEOUT_TICKS = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] text,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic [127:0] result,
  output logic [8:0]   aes_tx,
  input  logic [8:0]   aes_rx
);

  localparam int DIV  = calc_div(CLK_FREQ, AES_TX_FREQ);
  localparam int TO_W = cnt_w(TIMEOUT_TICKS + 1);
  localparam int TX_W = cnt_w(TX_BYTES);
  localparam int RX_W = cnt_w(RX_BYTES);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("aes_chip_link: CLK_FREQ/AES_TX_FREQ must be at least 2");
    end
  endgenerate

  state_t          state;
  logic [255:0]    shreg;
  logic [TX_W-1:0] tx_cnt;
  logic [RX_W-1:0] rx_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [127:0]    acc;
  logic [8:0]      rx_s1, rx_s2;
  logic            rx_stb_d;
  logic            rx_edge;
  logic            tick;

  assign busy    = (state != IDLE);
  assign rx_edge = rx_s2[STB] & ~rx_stb_d;

  // Divider held cleared in IDLE so every frame starts on a fresh tick phase.
  aes_link_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1    <= '0;
      rx_s2    <= '0;
      rx_stb_d <= 1'b0;
    end else begin
      rx_s1    <= aes_rx;
      rx_s2    <= rx_s1;
      rx_stb_d <= rx_s2[STB];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      tx_cnt  <= '0;
      rx_cnt  <= '0;
      to_cnt  <= '0;
      acc     <= '0;
      result  <= '0;
      aes_tx  <= '0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: if (start) begin
          shreg  <= {key, text};
          tx_cnt <= '0;
          aes_tx <= {1'b1, key[127:120]};
          state  <= TX_HI;
        end
        TX_HI: if (tick) begin
          aes_tx[STB] <= 1'b0;
          state       <= TX_LO;
        end
        TX_LO: if (tick) begin
          if (tx_cnt == TX_W'(TX_BYTES - 1)) begin
            aes_tx <= '0;
            rx_cnt <= '0;
            to_cnt <= '0;
            acc    <= '0;
            state  <= WAIT_RX;
          end else begin
            shreg  <= shreg << 8;
            tx_cnt <= tx_cnt + TX_W'(1);
            aes_tx <= {1'b1, shreg[247:240]};
            state  <= TX_HI;
          end
        end
        WAIT_RX: begin
          // A captured byte takes priority over a coincident timeout tick.
          if (rx_edge) begin
            acc    <= {acc[119:0], rx_s2[7:0]};
            rx_cnt <= rx_cnt + RX_W'(1);
            to_cnt <= '0;
            if (rx_cnt == RX_W'(RX_BYTES - 1)) begin
              result <= {acc[119:0], rx_s2[7:0]};
              done   <= 1'b1;
              state  <= IDLE;
            end
          end else if (tick) begin
            to_cnt <= to_cnt + TO_W'(1);
            if (to_cnt == TO_W'(TIMEOUT_TICKS - 1)) begin
              timeout <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
